// File: rtl/simon_key_schedule.sv
// Simon32/64 round-key generator: streams k[0..ROUNDS-1] over a valid/ready
// handshake from a sliding four-word window.
module simon_key_schedule #(
    parameter int          ROUNDS = 32,
    parameter logic [61:0] Z_SEQ  = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        rk_ready,
    output logic        rk_valid,
    output logic [15:0] rk,
    output logic [4:0]  rk_index,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    // Ascending range so that z index 0 is the leftmost character of Z_SEQ.
    localparam logic [0:61] Z_ASC = Z_SEQ;
    localparam logic [4:0]  LAST  = 5'(ROUNDS - 1);

    state_t      state;
    logic [15:0] w0, w1, w2, w3;
    logic [4:0]  i;
    logic [15:0] t_rot, t_mix, knew;
    logic        z_bit;
    logic        transfer;

    always_comb begin
        z_bit    = Z_ASC[i];
        t_rot    = {w3[2:0], w3[15:3]} ^ w1;
        t_mix    = t_rot ^ {t_rot[0], t_rot[15:1]};
        knew     = ~w0 ^ t_mix ^ {15'b0, z_bit} ^ 16'h0003;
        transfer = (state == RUN) && rk_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            i     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w0    <= key[15:0];
                        w1    <= key[31:16];
                        w2    <= key[47:32];
                        w3    <= key[63:48];
                        i     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (transfer) begin
                        if (i == LAST) begin
                            // Window is left in place so rk/rk_index hold the last key.
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            w0 <= w1;
                            w1 <= w2;
                            w2 <= w3;
                            w3 <= knew;
                            i  <= i + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rk_valid = (state == RUN);
        busy     = (state == RUN);
        rk       = w0;
        rk_index = i;
    end

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule: reference key expansion, back-pressure,
// ignored restarts, async reset mid-run and back-to-back starts.
module tb_simon_key_schedule;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic        rk_ready;
    logic        rk_valid;
    logic [15:0] rk;
    logic [4:0]  rk_index;
    logic        busy;
    logic        done;

    int applied = 0;
    int errors  = 0;

    logic [15:0] exp_rk [0:31];
    logic [15:0] ref_head [0:4];

    localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY_B = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] KEY_C = 64'h0F1E_2D3C_4B5A_6978;

    simon_key_schedule #(.ROUNDS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        applied++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Textbook Simon form: k[j] = c ^ z ^ k[j-4] ^ (I ^ S^-1) (S^-3 k[j-1] ^ k[j-3]), c = 0xFFFC.
    function automatic void build(input logic [63:0] k);
        logic [61:0] z0;
        logic [15:0] kk [0:31];
        logic [15:0] tmp;
        z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int j = 0; j < 4; j++) kk[j] = k[16*j +: 16];
        for (int j = 4; j < 32; j++) begin
            tmp   = {kk[j-1][2:0], kk[j-1][15:3]} ^ kk[j-3];
            tmp   = tmp ^ {tmp[0], tmp[15:1]};
            kk[j] = kk[j-4] ^ tmp ^ 16'hFFFC ^ {15'b0, z0[61-j+4]};
        end
        for (int j = 0; j < 32; j++) exp_rk[j] = kk[j];
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge where done
    // should be high, or right after index stop_at has been checked.
    task automatic run_seq(input logic [63:0] k, input bit rand_ready, input bit poke,
                           input bit check_head, input int stop_at);
        int  j;
        int  cycles;
        bit  adv;
        build(k);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = KEY_C;
        j      = 0;
        cycles = 0;
        while (j < 32 && cycles < 400) begin
            check("rk_valid", {31'b0, rk_valid}, 32'd1);
            check("busy", {31'b0, busy}, 32'd1);
            check("rk_index", {27'b0, rk_index}, j);
            check("rk", {16'b0, rk}, {16'b0, exp_rk[j]});
            if (check_head && j < 5) check("rk_ref", {16'b0, rk}, {16'b0, ref_head[j]});
            if (j == stop_at) return;
            if (poke) begin
                start = ($urandom_range(0, 2) == 0);
                key   = KEY_C ^ 64'($urandom);
            end
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            adv = rk_ready;
            @(negedge clk);
            if (adv) j++;
            cycles++;
        end
        start = 1'b0;
        check("seq_complete", j, 32'd32);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("valid_after_last", {31'b0, rk_valid}, 32'd0);
        check("busy_after_last", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        ref_head[0] = 16'h0100;
        ref_head[1] = 16'h0908;
        ref_head[2] = 16'h1110;
        ref_head[3] = 16'h1918;
        ref_head[4] = 16'h71C3;

        reset    = 1'b1;
        start    = 1'b0;
        key      = '0;
        rk_ready = 1'b0;
        #12;
        check("rst_valid", {31'b0, rk_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rk", {16'b0, rk}, 32'h0);
        check("rst_index", {27'b0, rk_index}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Ready alone in IDLE must not start anything.
        rk_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_valid", {31'b0, rk_valid}, 32'd0);
            check("idle_done", {31'b0, done}, 32'd0);
        end

        // Reference key, ready always high.
        run_seq(KEY_A, 1'b0, 1'b0, 1'b1, -1);
        @(negedge clk);
        check("done_single", {31'b0, done}, 32'd0);
        check("hold_index", {27'b0, rk_index}, 32'd31);

        // Random back-pressure.
        run_seq(KEY_A, 1'b1, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("done_single_bp", {31'b0, done}, 32'd0);

        // Restarts with a different key during RUN are ignored.
        run_seq(KEY_A, 1'b1, 1'b1, 1'b0, -1);
        // Start in the done cycle is accepted.
        run_seq(KEY_B, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("done_single_b2b", {31'b0, done}, 32'd0);

        // Asynchronous reset mid-run, between clock edges.
        rk_ready = 1'b1;
        run_seq(KEY_A, 1'b0, 1'b0, 1'b0, 10);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", {31'b0, rk_valid}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_rk", {16'b0, rk}, 32'h0);
        check("arst_index", {27'b0, rk_index}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_resume", {31'b0, rk_valid}, 32'd0);
        end
        run_seq(KEY_B ^ 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("done_single_post_rst", {31'b0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule

// File: doc/simon_key_schedule.md
SIMON_KEY_SCHEDULE -- requirements
Module: simon_key_schedule

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, meaning the number of round keys emitted per key load (Simon32/64).
REQ-002 SHALL have parameter Z_SEQ, default 62'b11111010001001010110000111001101111101000100101011000011100110, meaning the z0 constant sequence with bit index 0 as the leftmost character.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to load a key and begin expansion.
REQ-006 SHALL have port key, input, 64 bits: master key; key[15:0]=k0, key[31:16]=k1, key[47:32]=k2, key[63:48]=k3.
REQ-007 SHALL have port rk_ready, input, 1 bit: downstream round register accepts rk this cycle; this signal drives the enable of the downstream n_bit_dffe.
REQ-008 SHALL have port rk_valid, output, 1 bit: rk and rk_index are valid.
REQ-009 SHALL have port rk, output, 16 bits: current round key k[i].
REQ-010 SHALL have port rk_index, output, 5 bits: current round number i.
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse after the last round key is accepted.

Function
REQ-013 SHALL implement states IDLE and RUN; reset state is IDLE.
REQ-014 SHALL hold a 4-word window W0..W3, where W0 is k[i] and W3 is k[i+3], plus a 5-bit round counter i.
REQ-015 In IDLE with start=1, SHALL load W0..W3 = k0..k3, set i=0, and enter RUN; rk_valid SHALL be 1 on the following cycle (1-cycle latency).
REQ-016 In RUN, SHALL drive rk_valid=1, rk=W0, rk_index=i, busy=1.
REQ-017 A transfer SHALL occur only on a cycle with rk_valid=1 and rk_ready=1; without a transfer, rk and rk_index SHALL hold stable.
REQ-018 On a transfer with i<ROUNDS-1: W0<=W1, W1<=W2, W2<=W3, W3<=knew, i<=i+1.
REQ-019 knew: t = ROR3(W3) xor W1; t = t xor ROR1(t); knew = ~W0 xor t xor {15'b0, Z_SEQ[i]} xor 16'h0003; all arithmetic is 16-bit with no carries.
REQ-020 The z index SHALL equal i; z indices 0..27 are used, and no wrap logic is required for ROUNDS<=62.
REQ-021 On a transfer with i=ROUNDS-1: return to IDLE, rk_valid=0 next cycle, and done=1 for exactly that one next cycle.
REQ-022 start SHALL be ignored while in RUN (no reload, no disturbance to the sequence).
REQ-023 start asserted in the same cycle done is high (IDLE) SHALL be accepted normally.
REQ-024 In IDLE, rk_valid=0 and busy=0; rk and rk_index SHALL hold their last values and are don't-care to consumers.
REQ-025 rk_ready in IDLE SHALL have no effect.

Reset
REQ-026 Asserting reset at any time, including mid-RUN, SHALL immediately force IDLE, rk_valid=0, busy=0, done=0, rk=16'h0000, rk_index=0, W0..W3=0, i=0.
REQ-027 After reset deasserts, the block SHALL require a new start; no partial sequence SHALL resume.

Verification
REQ-028 Load key=64'h1918_1110_0908_0100 with rk_ready held at 1 -> rk = 0100, 0908, 1110, 1918, 71C3 for indices 0..4 on consecutive cycles; all 32 keys SHALL match a software Simon32/64 model, with done pulsing once after index 31.
REQ-029 Same key with rk_ready randomly toggled -> identical rk sequence, with rk and rk_index stable on every valid&!ready cycle.
REQ-030 start pulsed repeatedly with a different key during RUN -> output sequence unchanged from the original key.
REQ-031 reset asserted asynchronously at index 10 -> outputs clear without waiting for a clk edge; a fresh start with a new key then yields correct keys from index 0.
REQ-032 start asserted in the done cycle -> new sequence begins, with rk_valid=1 and index 0 on the next cycle.
REQ-033 rk_ready=1 with no start in IDLE -> rk_valid and done remain 0.
